// File: rtl/sw_btn_conditioner.sv
// Input conditioner for board switches and a push-button: each input is synchronised
// into clk and debounced. Outputs are clean levels plus registered one-cycle strobes.
// Optional build macro: LONG_PRESS_EN enables the long-press detector behind btn_long.
module sw_btn_conditioner #(
  parameter int unsigned N_SW            = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  input  logic            btn_raw,
  output logic [N_SW-1:0] sw_clean,
  output logic            sw_changed,
  output logic            btn_level,
  output logic            btn_press,
  output logic            btn_release,
  output logic            btn_long
);

  // Switches occupy the low bits, the button is the top bit.
  localparam int unsigned NIn    = N_SW + 1;
  localparam int unsigned BtnIdx = N_SW;
  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  if (N_SW < 1) begin : gen_bad_n_sw
    $error("N_SW must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : gen_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : gen_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 2) begin : gen_bad_long
    $error("LONG_CYCLES must be >= 2");
  end

  logic [NIn-1:0]                   raw_in;
  logic [SYNC_STAGES-1:0][NIn-1:0]  sync_q;
  logic [NIn-1:0]                   sync_val;
  logic [NIn-1:0][CntW-1:0]         cnt_q, cnt_d;
  logic [NIn-1:0]                   clean_q, clean_d;
  logic [NIn-1:0]                   upd;
  logic                             sw_changed_q, btn_press_q, btn_release_q;

  assign raw_in   = {btn_raw, sw_raw};
  assign sync_val = sync_q[SYNC_STAGES-1];

  // Synchroniser chains: stage 0 samples the raw pins, the last stage feeds the debouncers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  // Debounce next-state: any agreement with the clean level cancels an in-progress count.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    upd     = '0;
    for (int i = 0; i < NIn; i++) begin
      if (sync_val[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        clean_d[i] = sync_val[i];
        cnt_d[i]   = '0;
        upd[i]     = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  // Debounce state and registered strobes, aligned with the clean-level update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      clean_q       <= '0;
      sw_changed_q  <= 1'b0;
      btn_press_q   <= 1'b0;
      btn_release_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      clean_q       <= clean_d;
      sw_changed_q  <= |upd[N_SW-1:0];
      btn_press_q   <= upd[BtnIdx] & sync_val[BtnIdx];
      btn_release_q <= upd[BtnIdx] & ~sync_val[BtnIdx];
    end
  end

  assign sw_clean    = clean_q[N_SW-1:0];
  assign sw_changed  = sw_changed_q;
  assign btn_level   = clean_q[BtnIdx];
  assign btn_press   = btn_press_q;
  assign btn_release = btn_release_q;

`ifdef LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_CYCLES);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES - 1);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  // Hold counter reads 0 in the press cycle, so it reaches HoldMax in cycle LONG_CYCLES;
  // the pulse fires only on the transition into saturation, giving one pulse per press.
  always_comb begin
    hold_d = hold_q;
    if (upd[BtnIdx] && sync_val[BtnIdx]) begin
      hold_d = '0;
    end else if (clean_q[BtnIdx] && (hold_q != HoldMax)) begin
      hold_d = hold_q + HoldW'(1);
    end
    long_d = clean_d[BtnIdx] && (hold_d == HoldMax) && (hold_q != HoldMax);
  end

  // Long-press state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign btn_long = long_q;
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_sw_btn_conditioner.sv
// Self-checking bench for sw_btn_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// LONG_CYCLES=8, N_SW=2. Table-driven vectors plus hand-written multi-cycle sequences.
module tb_sw_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw_raw;
  logic       btn_raw;
  logic [1:0] sw_clean;
  logic       sw_changed, btn_level, btn_press, btn_release, btn_long;

  int errors = 0;
  int checks = 0;

  sw_btn_conditioner #(
    .N_SW           (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .btn_raw    (btn_raw),
    .sw_clean   (sw_clean),
    .sw_changed (sw_changed),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] sw;
    logic       btn;
    logic [1:0] clean;
    logic       chg;
    logic       lvl;
    logic       press;
    logic       rel;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int n, logic r, logic [1:0] sw, logic b, logic [1:0] c,
                              logic chg, logic lvl, logic pr, logic rl);
    vec_t v;
    v.rst = r; v.sw = sw; v.btn = b; v.clean = c;
    v.chg = chg; v.lvl = lvl; v.press = pr; v.rel = rl;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // {sw_clean, sw_changed, btn_level, btn_press, btn_release, btn_long}
  function automatic logic [31:0] outs();
    return {25'd0, sw_clean, sw_changed, btn_level, btn_press, btn_release, btn_long};
  endfunction

  task automatic wait_press(input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (btn_press) ok = 1'b1;
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_release(input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (btn_release) ok = 1'b1;
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int  press_cnt, press_at, rel_cnt, chg_cnt, long_cnt, long_at;
    bit  ok;
    int  exp_long_cnt, exp_long_at;

    rst = 1'b1; sw_raw = 2'b00; btn_raw = 1'b0;

    // Reset with inputs high, then power-up settling (edge 6 after release).
    add(3, 1, 2'b11, 1, 2'b00, 0, 0, 0, 0);
    add(5, 0, 2'b11, 1, 2'b00, 0, 0, 0, 0);
    add(1, 0, 2'b11, 1, 2'b11, 1, 1, 1, 0);
    add(1, 0, 2'b11, 1, 2'b11, 0, 1, 0, 0);
    // Everything back to 0: one strobe for both bits, button release pulse.
    add(5, 0, 2'b00, 0, 2'b11, 0, 1, 0, 0);
    add(1, 0, 2'b00, 0, 2'b00, 1, 0, 0, 1);
    add(1, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    // Single bit 00 -> 10.
    add(5, 0, 2'b10, 0, 2'b00, 0, 0, 0, 0);
    add(1, 0, 2'b10, 0, 2'b10, 1, 0, 0, 0);
    add(1, 0, 2'b10, 0, 2'b10, 0, 0, 0, 0);
    // Both bits on the same cycle: 10 -> 01, one strobe.
    add(5, 0, 2'b01, 0, 2'b10, 0, 0, 0, 0);
    add(1, 0, 2'b01, 0, 2'b01, 1, 0, 0, 0);
    add(1, 0, 2'b01, 0, 2'b01, 0, 0, 0, 0);
    // Bit0 falls, bit1 rises two cycles later: two strobes two cycles apart.
    add(2, 0, 2'b00, 0, 2'b01, 0, 0, 0, 0);
    add(3, 0, 2'b10, 0, 2'b01, 0, 0, 0, 0);
    add(1, 0, 2'b10, 0, 2'b00, 1, 0, 0, 0);
    add(1, 0, 2'b10, 0, 2'b00, 0, 0, 0, 0);
    add(1, 0, 2'b10, 0, 2'b10, 1, 0, 0, 0);
    add(1, 0, 2'b10, 0, 2'b10, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst     = vecs[i].rst;
      sw_raw  = vecs[i].sw;
      btn_raw = vecs[i].btn;
      tick();
      check($sformatf("vec%0d", i), outs(),
            {25'd0, vecs[i].clean, vecs[i].chg, vecs[i].lvl, vecs[i].press, vecs[i].rel,
             1'b0});
    end

    // Bounce: 1 for 3 cycles, 0 for 1, then 1 held; level rises on edge 10.
    press_cnt = 0; press_at = 0; rel_cnt = 0; chg_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      btn_raw = (c == 4) ? 1'b0 : 1'b1;
      tick();
      if (btn_press) begin press_cnt++; press_at = c; end
      if (btn_release) rel_cnt++;
      if (sw_changed) chg_cnt++;
    end
    check("bounce_press_count", press_cnt, 1);
    check("bounce_press_edge", press_at, 10);
    check("bounce_release_count", rel_cnt, 0);
    check("bounce_sw_changed", chg_cnt, 0);
    check("bounce_level", {31'd0, btn_level}, 1);

    // Reset while bit0 counter sits at 2; full latency must restart.
    sw_raw = 2'b11;
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_a", outs(), 0);
    tick();
    check("rst_mid_b", outs(), 0);
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c < 6) check($sformatf("rst_wait%0d", c), outs(), 0);
      else       check("rst_done", outs(), {25'd0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    end

`ifdef LONG_PRESS_EN
    exp_long_cnt = 1; exp_long_at = 8;
`else
    exp_long_cnt = 0; exp_long_at = 0;
`endif

    // Long hold: press cycle counts as cycle 1.
    btn_raw = 1'b0;
    wait_release("long_prep_release", ok);
    for (int c = 0; c < 3; c++) tick();
    btn_raw = 1'b1;
    wait_press("long_press_seen", ok);
    long_cnt = 0; long_at = 0;
    if (btn_long) begin long_cnt++; long_at = 1; end
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (btn_long) begin long_cnt++; long_at = c; end
    end
    check("long_count", long_cnt, exp_long_cnt);
    check("long_cycle", long_at, exp_long_at);

    // Short press released well before LONG_CYCLES.
    btn_raw = 1'b0;
    wait_release("short_prep_release", ok);
    for (int c = 0; c < 3; c++) tick();
    btn_raw = 1'b1;
    wait_press("short_press_seen", ok);
    btn_raw = 1'b0;
    long_cnt = 0; rel_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (btn_long) long_cnt++;
      if (btn_release) rel_cnt++;
    end
    check("short_long_count", long_cnt, 0);
    check("short_release_count", rel_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
